// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Writeback scheduler for a 2-write-port register file. It shares the two ports
//   among NUM_REQ writeback sources with round-robin arbitration. Up to two writes
//   are granted per cycle, and the granted writes are registered for the port.
//   x0 writes are swallowed here. Same-address pairs are split across cycles, so the
//   register file never sees two writes to one address in a single cycle.
//
//   Ports
//     i_clk, i_rst_n       clock; asynchronous active-low reset
//     i_hold               freeze: no grants this cycle
//     i_req_valid/addr/data per-requester write request (held until ready)
//     o_req_ready          combinational grant per requester
//     o_w_en/addr/data     registered write port 0 (index 0) and port 1 (index 1)
//     o_busy               any request pending or any write in flight
//     o_stat_writes/conflicts  (only when RF_WB_ARB_STATS_EN is defined)
//
//   Optional feature macro: RF_WB_ARB_STATS_EN adds the statistics counters.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_hold,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [1:0]                     o_w_en,
  output logic [1:0][ADDR_W-1:0]         o_w_addr,
  output logic [1:0][DATA_W-1:0]         o_w_data,
  output logic                           o_busy
`ifdef RF_WB_ARB_STATS_EN
  ,
  output logic [31:0]                    o_stat_writes,
  output logic [31:0]                    o_stat_conflicts
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]                w_en_q, w_en_d;
  logic [1:0][ADDR_W-1:0]    w_addr_q, w_addr_d;
  logic [1:0][DATA_W-1:0]    w_data_q, w_data_d;

  logic                      g0_vld, g1_vld;
  logic [PTR_W-1:0]          g0_idx, g1_idx;
  logic                      arb_en;
  logic [NUM_REQ-1:0]        gnt;

  // Grants are suppressed during reset so ready never rises before the first edge.
  assign arb_en = i_rst_n & ~i_hold;

  // Round-robin scan starting at rr_ptr. Slot 0 takes the first valid requester;
  // slot 1 takes the next valid one whose nonzero address differs from slot 0's.
  always_comb begin
    logic [IDX_W-1:0] sum;
    logic [PTR_W-1:0] cand;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = IDX_W'({1'b0, rr_ptr_q}) + IDX_W'(k);
      if (sum >= IDX_W'(NUM_REQ)) sum = sum - IDX_W'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (i_req_valid[cand]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = cand;
        end else if (!g1_vld &&
                     !((i_req_addr[cand] != '0) && (i_req_addr[cand] == i_req_addr[g0_idx]))) begin
          g1_vld = 1'b1;
          g1_idx = cand;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
    assign gnt[gi] = arb_en & ((g0_vld & (g0_idx == PTR_W'(gi))) |
                               (g1_vld & (g1_idx == PTR_W'(gi))));
  end
  assign o_req_ready = gnt;

  // Next-state for the output stage and pointer. An x0 grant loads addr/data but
  // leaves the enable low; an unused slot keeps its previous addr/data.
  always_comb begin
    logic [PTR_W-1:0] last;
    logic [IDX_W-1:0] nxt;
    w_en_d   = 2'b00;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    rr_ptr_d = rr_ptr_q;
    last     = g1_vld ? g1_idx : g0_idx;
    nxt      = IDX_W'({1'b0, last}) + IDX_W'(1);
    if (arb_en && g0_vld) begin
      w_en_d[0]   = (i_req_addr[g0_idx] != '0);
      w_addr_d[0] = i_req_addr[g0_idx];
      w_data_d[0] = i_req_data[g0_idx];
      rr_ptr_d    = (nxt == IDX_W'(NUM_REQ)) ? '0 : nxt[PTR_W-1:0];
    end
    if (arb_en && g1_vld) begin
      w_en_d[1]   = (i_req_addr[g1_idx] != '0);
      w_addr_d[1] = i_req_addr[g1_idx];
      w_data_d[1] = i_req_data[g1_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign o_w_en   = w_en_q;
  assign o_w_addr = w_addr_q;
  assign o_w_data = w_data_q;
  assign o_busy   = (|i_req_valid) | (|w_en_q);

`ifdef RF_WB_ARB_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_cf_q, stat_cf_d;

  // A conflict cycle is any unfrozen cycle that leaves a valid request waiting,
  // whether it lost to an address collision or simply ran out of slots.
  always_comb begin
    stat_wr_d = stat_wr_q + 32'(w_en_q[0]) + 32'(w_en_q[1]);
    stat_cf_d = stat_cf_q;
    if (arb_en && (|(i_req_valid & ~gnt))) stat_cf_d = stat_cf_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_wr_q <= '0;
      stat_cf_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_cf_q <= stat_cf_d;
    end
  end

  assign o_stat_writes    = stat_wr_q;
  assign o_stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   hold = 1'b0;
  logic [N-1:0]           vld = '0;
  logic [N-1:0][AW-1:0]   addr = '0;
  logic [N-1:0][DW-1:0]   data = '0;
  logic [N-1:0]           rdy;
  logic [1:0]             w_en;
  logic [1:0][AW-1:0]     w_addr;
  logic [1:0][DW-1:0]     w_data;
  logic                   busy;
`ifdef RF_WB_ARB_STATS_EN
  logic [31:0]            st_wr, st_cf;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold),
    .i_req_valid(vld), .i_req_addr(addr), .i_req_data(data),
    .o_req_ready(rdy), .o_w_en(w_en), .o_w_addr(w_addr), .o_w_data(w_data),
    .o_busy(busy)
`ifdef RF_WB_ARB_STATS_EN
    , .o_stat_writes(st_wr), .o_stat_conflicts(st_cf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pointer as an integer, output stage as plain arrays.
  int                  m_ptr;
  bit [1:0]            m_en;
  bit [1:0][AW-1:0]    m_addr;
  bit [1:0][DW-1:0]    m_data;
  bit [31:0]           m_sw, m_sc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_en = '0; m_addr = '0; m_data = '0; m_sw = '0; m_sc = '0;
  endfunction

  // Pending requesters listed in round-robin order; first one wins slot 0, the
  // first later one that does not share slot 0's nonzero address wins slot 1.
  function automatic void model_grants(output int g0, output int g1);
    int q[$];
    g0 = -1; g1 = -1;
    for (int k = 0; k < N; k++)
      if (vld[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
    if (q.size() == 0) return;
    g0 = q.pop_front();
    foreach (q[j])
      if (g1 < 0 && (addr[q[j]] == 0 || addr[q[j]] != addr[g0])) g1 = q[j];
  endfunction

  // One clock: compare at negedge, advance model after posedge.
  task automatic cycle(output logic [N-1:0] gnt);
    int g0, g1;
    logic [N-1:0] eg;
    bit [1:0] pen;
    @(negedge clk);
    eg = '0; g0 = -1; g1 = -1;
    if (rst_n && !hold) begin
      model_grants(g0, g1);
      if (g0 >= 0) eg[g0] = 1'b1;
      if (g1 >= 0) eg[g1] = 1'b1;
    end
    chk("ready",  rdy,    eg);
    chk("w_en",   w_en,   m_en);
    chk("w_addr", w_addr, m_addr);
    chk("w_data", w_data, m_data);
    chk("busy",   busy,   (|vld) || (|m_en));
`ifdef RF_WB_ARB_STATS_EN
    chk("stat_writes",    st_wr, m_sw);
    chk("stat_conflicts", st_cf, m_sc);
`endif
    gnt = eg;
    pen = m_en;
    @(posedge clk); #1;
    if (!rst_n) model_reset();
    else begin
      m_sw += pen[0] + pen[1];
      if (!hold && ((vld & ~eg) != 0)) m_sc++;
      m_en = '0;
      if (g0 >= 0) begin m_en[0] = (addr[g0] != 0); m_addr[0] = addr[g0]; m_data[0] = data[g0]; end
      if (g1 >= 0) begin m_en[1] = (addr[g1] != 0); m_addr[1] = addr[g1]; m_data[1] = data[g1]; end
      if (g0 >= 0) m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % N;
    end
  endtask

  task automatic do_reset();
    logic [N-1:0] g;
    rst_n = 1'b0; model_reset();
    cycle(g);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] g;
    model_reset();

    // Reset with everything requesting.
    vld = '1;
    for (int i = 0; i < N; i++) begin addr[i] = AW'(i + 1); data[i] = 32'h1000 + i; end
    repeat (2) cycle(g);
    chk("rst_ready", rdy, 0);
    chk("rst_wen", w_en, 0);
    rst_n = 1'b1;
    #1 chk("release_ready", rdy, 4'b0011);

    // Continuous round-robin with distinct addresses.
    cycle(g);
    chk("rr_wen", w_en, 2'b11);
    chk("rr_addr", w_addr, {7'd2, 7'd1});
    chk("rr_ready2", rdy, 4'b1100);
    cycle(g);
    chk("rr_ready3", rdy, 4'b0011);
    cycle(g);

    // Async reset between edges while both ports are writing.
    #2 rst_n = 1'b0;
    #1 chk("async_rst_wen", w_en, 2'b00);
    model_reset();
    cycle(g);
    rst_n = 1'b1;

    // Dual grant from rr_ptr=0.
    vld = 4'b0110;
    addr[1] = 7'd5; data[1] = 32'hAAAA;
    addr[2] = 7'd9; data[2] = 32'hBBBB;
    #1 chk("dual_ready", rdy, 4'b0110);
    cycle(g);
    vld = '0;
    chk("dual_wen", w_en, 2'b11);
    chk("dual_addr", w_addr, {7'd9, 7'd5});
    chk("dual_data", w_data, {32'hBBBB, 32'hAAAA});
    // rr_ptr is now 3: req3 comes ahead of req0.
    vld = 4'b1001; addr[0] = 7'd3; addr[3] = 7'd4;
    #1 chk("ptr3_ready", rdy, 4'b1001);
    cycle(g);
    vld = '0;
    chk("ptr3_slot0", w_addr[0], 7'd4);
    cycle(g);

    // Collision on address 12.
    do_reset();
    vld = 4'b0011; addr[0] = 7'd12; addr[1] = 7'd12; data[0] = 32'h0C0; data[1] = 32'h0C1;
    #1 chk("coll_ready1", rdy, 4'b0001);
    cycle(g);
    vld[0] = 1'b0;
    chk("coll_ready2", rdy, 4'b0010);
    chk("coll_data1", w_data[0], 32'h0C0);
    cycle(g);
    vld = '0;
    chk("coll_data2", w_data[0], 32'h0C1);
    chk("coll_wen", w_en, 2'b01);
`ifdef RF_WB_ARB_STATS_EN
    chk("coll_conflicts", st_cf, 32'd1);
`endif
    cycle(g);

    // x0 write then hold.
    do_reset();
    vld = 4'b1001; addr[0] = 7'd0; addr[3] = 7'd4;
    #1 chk("x0_ready", rdy, 4'b1001);
    cycle(g);
    vld = 4'b0100; addr[2] = 7'd20; hold = 1'b1;
    chk("x0_wen", w_en, 2'b10);
    repeat (3) begin
      cycle(g);
      chk("hold_ready", rdy, 4'b0000);
      chk("hold_wen", w_en, 2'b00);
    end
    hold = 1'b0;
    #1 chk("hold_release", rdy, 4'b0100);
    cycle(g);
    vld = '0;
    cycle(g);

    // Randomized traffic with small address range to force collisions.
    for (int c = 0; c < 600; c++) begin
      cycle(g);
      vld = vld & ~g;
      for (int i = 0; i < N; i++)
        if (!vld[i] && ($urandom_range(99) < 60)) begin
          vld[i] = 1'b1; addr[i] = AW'($urandom_range(5)); data[i] = $urandom;
        end
      hold = ($urandom_range(99) < 10);
      if (c == 300) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_async_rst", w_en, 2'b00);
        model_reset();
        cycle(g);
        rst_n = 1'b1;
      end
    end
    hold = 1'b0; vld = '0;
    repeat (2) cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
